timer_ctrl: RTL and testbench
=============================

Name: timer_ctrl

Overview:
- Programmable interval timer that schedules hardware interrupts for the CPU in mini_machine.
- Sits on the CPU's I/O bus beside the display and switch devices; the CPU configures it through three word registers.
- Its irq output drives one HardInt line of the CPU.
- Two modes: one-shot (mode 0) and auto-reload periodic (mode 1).

Parameters:
- WIDTH, 32, width of the PRESET and COUNT registers and of the data bus.
- DIV, 1, prescale factor: COUNT decrements once every DIV clocks (DIV >= 1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- addr  in  2  word offset (CPU address bits [3:2]): 0 = CTRL, 1 = PRESET, 2 = COUNT, 3 = unused.
- we  in  1  write strobe, sampled on the rising edge.
- din  in  WIDTH  write data.
- dout  out  WIDTH  combinational read data for addr.
- irq  out  1  interrupt request to the CPU.

Behaviour:
- CTRL[0] EN, CTRL[2:1] MODE, CTRL[3] IM (interrupt mask, 1 = enabled). CTRL[31:4] read as 0.
- MODE 2 and 3 behave as mode 0.
- PRESET is read/write. COUNT is read-only; writes to it are ignored. addr 3 reads 0.
- Reset (reset = 0, asynchronous): CTRL = 0, PRESET = 0, COUNT = 0, prescaler = 0, state = IDLE, pending = 0, irq = 0. dout therefore reads 0.
- irq = IM & pending. It is registered-derived and has no combinational path from din.
- FSM states: IDLE, LOAD, CNT, INT.
  - IDLE: COUNT holds. If EN = 1, go to LOAD.
  - LOAD: COUNT <= PRESET; prescaler <= 0; go to CNT.
  - CNT: if EN = 0, go to IDLE with COUNT held. Else if COUNT = 0, go to INT and set pending. Else decrement COUNT on each tick.
  - INT, mode 0: clear EN and go to IDLE. pending stays set until any CPU write to CTRL or PRESET.
  - INT, mode 1: go to LOAD. pending clears on leaving INT, so it is high for exactly one cycle.
- Tick: asserted when prescaler = DIV-1, after which the prescaler wraps to 0. With DIV = 1 every cycle is a tick.
- Latency with DIV = 1: EN written at edge 0 gives LOAD at edge 1, COUNT = PRESET at edge 2, COUNT = 0 at edge PRESET+2, and INT with pending = 1 after edge PRESET+3.
  - Mode 1 period is PRESET+3 cycles.
  - PRESET = 0 gives irq after edge 3.
- A PRESET write during CNT does not affect the current count; it takes effect at the next LOAD.
- A CPU write in the same cycle as a state-machine update of CTRL (the EN clear in INT) wins: the written value is kept.
- A write to CTRL with EN = 1 while in CNT does not restart the count.
- Any CTRL or PRESET write clears pending; this takes priority over setting pending in the same cycle.
- COUNT arithmetic is unsigned WIDTH-bit. It never decrements below 0.
- Reset asserted mid-count returns everything to the reset values immediately, without waiting for a clock.

Decomposition:
- The shared `include header holds the register offset defines (CTRL, PRESET, COUNT), the mode codes (ONESHOT = 0, PERIODIC = 1), the CTRL bit positions, and the 2-bit FSM state encodings.
- One sub-module, timer_tick_gen: the DIV prescaler.
  - Inputs: clk, reset, clr (driven in LOAD), en (in CNT).
  - Output: tick.
  - DIV = 1 degenerates to tick = en.

Test Plan:
- One-shot: PRESET = 5, then CTRL = 0x9 (EN, mode 0, IM).
  - COUNT reads 5,4,3,2,1,0 on successive cycles.
  - irq rises after edge 8 and stays high.
  - CTRL[0] reads 0.
  - Writing CTRL = 0 drops irq the next cycle.
- Periodic: PRESET = 3, CTRL = 0xB.
  - irq is a one-cycle pulse every 6 cycles, first after edge 6.
  - Run 4 periods and confirm the pulse spacing is exactly 6.
- Mask and pause:
  - Mode 0 with IM = 0 and PRESET = 2: irq stays 0 while pending is set. Then write CTRL = 0x8: irq stays 0 because the write clears pending.
  - Mid-count, write EN = 0: COUNT freezes at its current value for 10 cycles.
- PRESET = 0 in mode 1: irq pulses every 3 cycles. A PRESET write to 4 mid-run takes effect at the following LOAD (period becomes 7).
- Prescaler, DIV = 4: PRESET = 2, mode 0.
  - COUNT changes every 4 cycles.
  - irq arrives after edge 2+8+1 = 11 counted from the EN write.
- Async reset: assert reset mid-count between clock edges. All registers, dout and irq are 0 immediately, and the block stays in IDLE after release.

Source files
------------

// File: rtl/timer_ctrl_pkg.sv
// Shared definitions for the interval timer: register offsets, mode codes,
// CTRL bit layout and FSM state encodings.
package timer_ctrl_pkg;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;

    localparam logic [1:0] MODE_ONESHOT  = 2'd0;
    localparam logic [1:0] MODE_PERIODIC = 2'd1;

    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_IM_BIT   = 3;
    localparam int CTRL_BITS     = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_CNT  = 2'd2;
    localparam logic [1:0] ST_INT  = 2'd3;

    // Field order matches the CTRL register bit layout (IM at bit 3, EN at bit 0).
    typedef struct packed {
        logic       im;
        logic [1:0] mode;
        logic       en;
    } ctrl_t;

endpackage

// File: rtl/timer_tick_gen.sv
// Prescaler: asserts tick once every DIV enabled cycles; clr restarts the phase.
module timer_tick_gen
    import timer_ctrl_pkg::*;
#(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    // A 1-bit counter that never leaves 0 keeps DIV = 1 equivalent to tick = en.
    localparam int            PW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] r_pre;

    assign tick = en && (r_pre == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pre <= '0;
        end else if (clr) begin
            r_pre <= '0;
        end else if (en) begin
            r_pre <= tick ? '0 : r_pre + PW'(1);
        end
    end

endmodule

// File: rtl/timer_ctrl.sv
// Programmable interval timer on the CPU I/O bus: CTRL/PRESET/COUNT registers,
// one-shot or auto-reload counting, and a maskable interrupt request.
module timer_ctrl
    import timer_ctrl_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIV   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       addr,
    input  logic             we,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             irq
);

    ctrl_t            r_ctrl;
    logic [WIDTH-1:0] r_preset;
    logic [WIDTH-1:0] r_count;
    logic [1:0]       r_state;
    logic             r_pending;

    ctrl_t w_din_ctrl;
    logic  w_wr_ctrl;
    logic  w_wr_preset;
    logic  w_load;
    logic  w_counting;
    logic  w_expire;
    logic  w_periodic;
    logic  w_tick;

    assign w_wr_ctrl   = we && (addr == ADDR_CTRL);
    assign w_wr_preset = we && (addr == ADDR_PRESET);

    assign w_din_ctrl.en   = din[CTRL_EN_BIT];
    assign w_din_ctrl.mode = din[CTRL_MODE_LSB +: 2];
    assign w_din_ctrl.im   = din[CTRL_IM_BIT];

    assign w_load     = (r_state == ST_LOAD);
    assign w_counting = (r_state == ST_CNT) && r_ctrl.en;
    assign w_expire   = w_counting && (r_count == '0);
    // Modes 2 and 3 fall through to one-shot behaviour.
    assign w_periodic = (r_ctrl.mode == MODE_PERIODIC);

    timer_tick_gen #(.DIV(DIV)) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .clr   (w_load),
        .en    (w_counting),
        .tick  (w_tick)
    );

    // NOTE: all state below uses non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ctrl   <= '0;
            r_preset <= '0;
        end else begin
            if (w_wr_ctrl) begin
                r_ctrl <= w_din_ctrl;
            end else if ((r_state == ST_INT) && !w_periodic) begin
                r_ctrl.en <= 1'b0;
            end
            if (w_wr_preset) begin
                r_preset <= din;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (r_ctrl.en) r_state <= ST_LOAD;
                ST_LOAD: begin
                    r_count <= r_preset;
                    r_state <= ST_CNT;
                end
                ST_CNT: begin
                    if (!r_ctrl.en) begin
                        r_state <= ST_IDLE;
                    end else if (r_count == '0) begin
                        r_state <= ST_INT;
                    end else if (w_tick) begin
                        r_count <= r_count - WIDTH'(1);
                    end
                end
                ST_INT:  r_state <= w_periodic ? ST_LOAD : ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // A CPU write acknowledges the interrupt, even in the cycle it would be raised.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pending <= 1'b0;
        end else if (w_wr_ctrl || w_wr_preset) begin
            r_pending <= 1'b0;
        end else if (w_expire) begin
            r_pending <= 1'b1;
        end else if ((r_state == ST_INT) && w_periodic) begin
            r_pending <= 1'b0;
        end
    end

    always_comb begin
        dout = '0;
        case (addr)
            ADDR_CTRL:   dout = {{(WIDTH-CTRL_BITS){1'b0}}, r_ctrl};
            ADDR_PRESET: dout = r_preset;
            ADDR_COUNT:  dout = r_count;
            default:     dout = '0;
        endcase
    end

    assign irq = r_ctrl.im & r_pending;

endmodule

// File: tb/tb_timer_ctrl.sv
// Self-checking bench for timer_ctrl: DIV=1 and DIV=4 instances share the bus;
// expectations are queued when a cycle is driven and compared on the next falling edge.
module tb_timer_ctrl;

    logic        clk;
    logic        reset;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] din;
    logic [31:0] dout1;
    logic [31:0] dout4;
    logic        irq1;
    logic        irq4;

    int    n_tests = 0;
    int    n_fail  = 0;
    int    tag_cnt = 0;
    string test_name = "init";

    typedef struct {
        logic        we;
        logic [1:0]  addr;
        logic [31:0] din;
        bit          chk_d;
        logic [31:0] exp_d;
        bit          chk_i;
        logic        exp_i;
    } vec_t;

    typedef struct {
        int          tag;
        bit          use4;
        bit          chk_d;
        logic [31:0] exp_d;
        bit          chk_i;
        logic        exp_i;
    } exp_t;

    exp_t sb[$];
    vec_t t_one[15];

    timer_ctrl #(.WIDTH(32), .DIV(1)) dut1 (
        .clk(clk), .reset(reset), .addr(addr), .we(we), .din(din), .dout(dout1), .irq(irq1)
    );

    timer_ctrl #(.WIDTH(32), .DIV(4)) dut4 (
        .clk(clk), .reset(reset), .addr(addr), .we(we), .din(din), .dout(dout4), .irq(irq4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s #%0d: got %h, expected %h", name, tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.chk_d) check({test_name, " dout"}, e.tag, e.use4 ? dout4 : dout1, e.exp_d);
            if (e.chk_i) check({test_name, " irq"}, e.tag, 32'(e.use4 ? irq4 : irq1), 32'(e.exp_i));
        end
    end

    function automatic vec_t mkv(input logic w, input logic [1:0] a, input logic [31:0] d,
                                 input bit cd, input logic [31:0] ed, input bit ci, input logic ei);
        vec_t v;
        v.we = w; v.addr = a; v.din = d; v.chk_d = cd; v.exp_d = ed; v.chk_i = ci; v.exp_i = ei;
        return v;
    endfunction

    // One clock: drive bus, queue what the chosen instance must show after the next edge.
    task automatic cyc(input logic w, input logic [1:0] a, input logic [31:0] d, input bit use4,
                       input bit cd, input logic [31:0] ed, input bit ci, input logic ei);
        exp_t e;
        @(negedge clk);
        #2;
        we = w; addr = a; din = d;
        e.tag = tag_cnt; e.use4 = use4; e.chk_d = cd; e.exp_d = ed; e.chk_i = ci; e.exp_i = ei;
        tag_cnt++;
        sb.push_back(e);
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        #2;
        reset = 1'b0; we = 1'b0; addr = 2'd0; din = '0;
        repeat (2) @(negedge clk);
        #2;
        reset = 1'b1;
        test_name = name;
        tag_cnt = 0;
    endtask

    initial begin
        reset = 1'b0; we = 1'b0; addr = 2'd0; din = '0;

        // One-shot, PRESET=5: CTRL write is edge 0, irq after edge 8.
        t_one[0]  = mkv(1, 2'd1, 32'd5,   1, 32'd5,   1, 0);
        t_one[1]  = mkv(1, 2'd0, 32'h9,   1, 32'h9,   1, 0);
        t_one[2]  = mkv(0, 2'd2, 32'd0,   1, 32'd0,   1, 0);
        t_one[3]  = mkv(0, 2'd2, 32'd0,   1, 32'd5,   1, 0);
        t_one[4]  = mkv(0, 2'd2, 32'd0,   1, 32'd4,   1, 0);
        t_one[5]  = mkv(0, 2'd2, 32'd0,   1, 32'd3,   1, 0);
        t_one[6]  = mkv(0, 2'd2, 32'd0,   1, 32'd2,   1, 0);
        t_one[7]  = mkv(0, 2'd2, 32'd0,   1, 32'd1,   1, 0);
        t_one[8]  = mkv(0, 2'd2, 32'd0,   1, 32'd0,   1, 0);
        t_one[9]  = mkv(0, 2'd2, 32'd0,   1, 32'd0,   1, 1);
        t_one[10] = mkv(0, 2'd0, 32'd0,   1, 32'h8,   1, 1);
        t_one[11] = mkv(0, 2'd0, 32'd0,   1, 32'h8,   1, 1);
        t_one[12] = mkv(1, 2'd0, 32'h0,   1, 32'h0,   1, 0);
        t_one[13] = mkv(0, 2'd0, 32'd0,   1, 32'h0,   1, 0);
        t_one[14] = mkv(0, 2'd3, 32'd0,   1, 32'h0,   1, 0);

        do_reset("reset_state");
        cyc(0, 2'd0, 0, 0, 1, 32'd0, 1, 0);
        cyc(0, 2'd1, 0, 0, 1, 32'd0, 1, 0);
        cyc(0, 2'd2, 0, 0, 1, 32'd0, 1, 0);
        cyc(1, 2'd2, 32'hFFFF, 0, 1, 32'd0, 1, 0);

        do_reset("oneshot");
        for (int i = 0; i < 15; i++)
            cyc(t_one[i].we, t_one[i].addr, t_one[i].din, 0,
                t_one[i].chk_d, t_one[i].exp_d, t_one[i].chk_i, t_one[i].exp_i);

        do_reset("periodic");
        cyc(1, 2'd1, 32'd3, 0, 1, 32'd3, 1, 0);
        cyc(1, 2'd0, 32'hB, 0, 1, 32'hB, 1, 0);
        for (int k = 1; k <= 27; k++)
            cyc(0, 2'd0, 0, 0, 1, 32'hB, 1, (k >= 6) && (k % 6 == 0));

        do_reset("mask");
        cyc(1, 2'd1, 32'd2, 0, 1, 32'd2, 1, 0);
        cyc(1, 2'd0, 32'h1, 0, 1, 32'h1, 1, 0);
        for (int k = 1; k <= 8; k++)
            cyc(0, 2'd0, 0, 0, 1, (k >= 6) ? 32'h0 : 32'h1, 1, 0);
        cyc(1, 2'd0, 32'h8, 0, 1, 32'h8, 1, 0);
        for (int k = 10; k <= 12; k++)
            cyc(0, 2'd0, 0, 0, 1, 32'h8, 1, 0);

        do_reset("pause");
        cyc(1, 2'd1, 32'd20, 0, 1, 32'd20, 1, 0);
        cyc(1, 2'd0, 32'h9, 0, 1, 32'h9, 1, 0);
        for (int k = 1; k <= 7; k++)
            cyc(0, 2'd2, 0, 0, 1, (k == 1) ? 32'd0 : 32'(22 - k), 1, 0);
        cyc(1, 2'd0, 32'h8, 0, 1, 32'h8, 1, 0);
        for (int k = 9; k <= 18; k++)
            cyc(0, 2'd2, 0, 0, 1, 32'd14, 1, 0);

        do_reset("preset0");
        cyc(1, 2'd1, 32'd0, 0, 1, 32'd0, 1, 0);
        cyc(1, 2'd0, 32'hB, 0, 1, 32'hB, 1, 0);
        for (int k = 1; k <= 30; k++) begin
            logic exp_irq;
            exp_irq = (k == 3) || (k == 6) || (k == 13) || (k == 20) || (k == 24) || (k == 28);
            if (k == 7)       cyc(1, 2'd1, 32'd4, 0, 1, 32'd4, 1, exp_irq);
            else if (k == 16) cyc(1, 2'd1, 32'd1, 0, 1, 32'd1, 1, exp_irq);
            else              cyc(0, 2'd0, 0,     0, 1, 32'hB, 1, exp_irq);
        end

        do_reset("div4");
        cyc(1, 2'd1, 32'd2, 1, 1, 32'd2, 1, 0);
        cyc(1, 2'd0, 32'h9, 1, 1, 32'h9, 1, 0);
        for (int k = 1; k <= 14; k++) begin
            logic [31:0] exp_cnt;
            exp_cnt = (k < 2) ? 32'd0 : (k < 6) ? 32'd2 : (k < 10) ? 32'd1 : 32'd0;
            cyc(0, 2'd2, 0, 1, 1, exp_cnt, 1, k >= 11);
        end

        do_reset("write_wins");
        cyc(1, 2'd1, 32'd1, 0, 1, 32'd1, 1, 0);
        cyc(1, 2'd0, 32'h9, 0, 1, 32'h9, 1, 0);
        for (int k = 1; k <= 10; k++) begin
            if (k == 5) cyc(1, 2'd0, 32'h9, 0, 1, 32'h9, 1, 0);
            else        cyc(0, 2'd0, 0, 0, 1, (k == 10) ? 32'h8 : 32'h9, 1, (k == 4) || (k >= 9));
        end

        do_reset("async_reset");
        cyc(1, 2'd1, 32'd10, 0, 1, 32'd10, 1, 0);
        cyc(1, 2'd0, 32'hB, 0, 1, 32'hB, 1, 0);
        for (int k = 1; k <= 5; k++)
            cyc(0, 2'd2, 0, 0, 1, (k == 1) ? 32'd0 : 32'(12 - k), 1, 0);
        @(negedge clk);
        #1;
        reset = 1'b0;
        we = 1'b0;
        for (int a = 0; a < 3; a++) begin
            addr = 2'(a);
            #1;
            check("async dout1", a, dout1, 32'd0);
            check("async dout4", a, dout4, 32'd0);
            check("async irq1", a, 32'(irq1), 32'd0);
        end
        @(negedge clk);
        #2;
        reset = 1'b1;
        for (int k = 0; k < 4; k++)
            cyc(0, 2'd2, 0, 0, 1, 32'd0, 1, 0);
        cyc(0, 2'd0, 0, 0, 1, 32'd0, 1, 0);
        cyc(0, 2'd1, 0, 0, 1, 32'd0, 1, 0);

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
